// File: rtl/game_timer_param_if.sv
// Control and status bundle for the parametrised game countdown timer.
// master drives the control strobes; slave (the timer) returns count and status.
interface game_timer_param_if #(
    parameter int CNT_W = 10
) ();
    logic             tick;
    logic             start;
    logic             pause;
    logic             restart;
    logic             load_en;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] count_out;
    logic             running;
    logic             paused;
    logic             done;
    logic             expired;
    logic             warn;

    modport master (
        output tick, start, pause, restart, load_en, load_val,
        input  count_out, running, paused, done, expired, warn
    );

    modport slave (
        input  tick, start, pause, restart, load_en, load_val,
        output count_out, running, paused, done, expired, warn
    );
endinterface

// File: rtl/game_timer_param.sv
// Parametrised game countdown timer: counts external ticks down from a loadable
// reload value, with pause, restart, runtime load, low-time warning and optional auto-reload.
module game_timer_param #(
    parameter int CNT_W       = 10,
    parameter int INIT_TICKS  = 600,
    parameter int WARN_TICKS  = 100,
    parameter int AUTO_RELOAD = 0
) (
    input  logic               clk,
    input  logic               rst,
    game_timer_param_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'(INIT_TICKS);
    localparam logic [31:0]      WARN_LIM = 32'(WARN_TICKS);

    state_t           state_reg,   state_next;
    logic [CNT_W-1:0] count_reg,   count_next;
    logic [CNT_W-1:0] reload_reg,  reload_next;
    logic             expired_reg, expired_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            count_reg   <= INIT_VAL;
            reload_reg  <= INIT_VAL;
            expired_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            reload_reg  <= reload_next;
            expired_reg <= expired_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        reload_next  = reload_reg;
        expired_next = 1'b0;

        if (bus.restart) begin
            // restart always uses the reload value held before this cycle
            count_next = reload_reg;
            state_next = ST_RUN;
        end else if (bus.load_en && (state_reg != ST_RUN)) begin
            reload_next = bus.load_val;
            count_next  = bus.load_val;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        state_next = ST_PAUSE;
                    end else if (count_reg == '0) begin
                        // zero is handled one cycle after it is reached; a zero reload
                        // cannot keep running, so it finishes even in auto-reload mode
                        expired_next = 1'b1;
                        if ((AUTO_RELOAD != 0) && (reload_reg != '0)) begin
                            count_next = reload_reg;
                        end else begin
                            state_next = ST_DONE;
                        end
                    end else if (bus.tick) begin
                        count_next = count_reg - CNT_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (!bus.pause) begin
                        state_next = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (bus.start) begin
                        count_next = reload_reg;
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.count_out = count_reg;
    assign bus.running   = (state_reg == ST_RUN);
    assign bus.paused    = (state_reg == ST_PAUSE);
    assign bus.done      = (state_reg == ST_DONE);
    assign bus.expired   = expired_reg;
    assign bus.warn      = (state_reg != ST_IDLE) && (count_reg != '0) &&
                           (32'(count_reg) <= WARN_LIM);

endmodule

// File: tb/tb_game_timer_param.sv
// Directed scoreboard bench for game_timer_param: one one-shot unit and one auto-reload unit.
module tb_game_timer_param;

    localparam int CNT_W = 10;
    localparam int IDLE  = 0;
    localparam int RUN   = 1;
    localparam int PAUSE = 2;
    localparam int DONE  = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    game_timer_param_if #(.CNT_W(CNT_W)) bus0 ();
    game_timer_param_if #(.CNT_W(CNT_W)) bus1 ();

    game_timer_param #(
        .CNT_W(CNT_W), .INIT_TICKS(600), .WARN_TICKS(100), .AUTO_RELOAD(0)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    game_timer_param #(
        .CNT_W(CNT_W), .INIT_TICKS(600), .WARN_TICKS(100), .AUTO_RELOAD(1)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct {
        string       tag;
        int          unit;
        logic [14:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // packed as {count, running, paused, done, expired, warn}
    function automatic logic [14:0] pack(input int cnt, input int st, input bit exp);
        logic w;
        logic [CNT_W-1:0] c;
        c = cnt[CNT_W-1:0];
        w = (cnt > 0) && (cnt <= 100) && (st != IDLE);
        return {c, st == RUN, st == PAUSE, st == DONE, exp, w};
    endfunction

    task automatic expect_state(input string tag, input int unit, input int cnt,
                                input int st, input bit exp);
        exp_t e;
        e.tag  = tag;
        e.unit = unit;
        e.val  = pack(cnt, st, exp);
        sb_q.push_back(e);
    endtask

    task automatic clock_and_check();
        exp_t        e;
        logic [14:0] obs;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.unit == 0)
                obs = {bus0.count_out, bus0.running, bus0.paused, bus0.done, bus0.expired, bus0.warn};
            else
                obs = {bus1.count_out, bus1.running, bus1.paused, bus1.done, bus1.expired, bus1.warn};
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s unit%0d observed cnt=%0d flags(r,p,d,e,w)=%b expected cnt=%0d flags=%b",
                       e.tag, e.unit, obs[14:5], obs[4:0], e.val[14:5], e.val[4:0]);
            end
        end
    endtask

    task automatic set_inputs(input int unit, input bit tk, input bit st, input bit ps,
                              input bit rs, input bit ld, input int lv);
        if (unit == 0) begin
            bus0.tick = tk; bus0.start = st; bus0.pause = ps;
            bus0.restart = rs; bus0.load_en = ld; bus0.load_val = lv[CNT_W-1:0];
        end else begin
            bus1.tick = tk; bus1.start = st; bus1.pause = ps;
            bus1.restart = rs; bus1.load_en = ld; bus1.load_val = lv[CNT_W-1:0];
        end
    endtask

    // One clock: drive inputs, record the expected post-edge outputs, compare, release.
    task automatic step(input string tag, input int unit, input bit tk, input bit st,
                        input bit ps, input bit rs, input bit ld, input int lv,
                        input int cnt, input int state, input bit exp);
        set_inputs(unit, tk, st, ps, rs, ld, lv);
        expect_state(tag, unit, cnt, state, exp);
        clock_and_check();
        set_inputs(unit, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic reset_unit0(input string tag);
        rst = 1'b1;
        expect_state(tag, 0, 600, IDLE, 1'b0);
        clock_and_check();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_inputs(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        set_inputs(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // reset state of both units
        for (int i = 0; i < 2; i++) begin
            expect_state("reset_u0", 0, 600, IDLE, 1'b0);
            expect_state("reset_u1", 1, 600, IDLE, 1'b0);
            clock_and_check();
        end
        rst = 1'b0;

        // load 5 in IDLE, start, count out, restart from DONE with start
        step("t3_load5",      0, 0, 0, 0, 0, 1, 5, 5, IDLE, 0);
        step("t3_idle_tick",  0, 1, 0, 0, 0, 0, 0, 5, IDLE, 0);
        step("t3_start",      0, 0, 1, 0, 0, 0, 0, 5, RUN,  0);
        for (int i = 1; i <= 5; i++)
            step($sformatf("t3_tick%0d", i), 0, 1, 0, 0, 0, 0, 0, 5 - i, RUN, 0);
        step("t3_expire",     0, 0, 0, 0, 0, 0, 0, 0, DONE, 1);
        step("t3_done_hold",  0, 1, 0, 0, 0, 0, 0, 0, DONE, 0);
        step("t3_restart",    0, 0, 1, 0, 0, 0, 0, 5, RUN,  0);
        reset_unit0("rst_mid_run");

        // full 600-tick countdown with warning window and saturation at zero
        step("t1_start",      0, 0, 1, 0, 0, 0, 0, 600, RUN, 0);
        for (int i = 1; i <= 600; i++)
            step($sformatf("t1_cnt%0d", 600 - i), 0, 1, 0, 0, 0, 0, 0, 600 - i, RUN, 0);
        step("t1_expire_sat", 0, 1, 0, 0, 0, 0, 0, 0, DONE, 1);
        step("t1_single_pulse", 0, 1, 0, 0, 0, 0, 0, 0, DONE, 0);
        step("t1_start_reload", 0, 0, 1, 0, 0, 0, 0, 600, RUN, 0);

        // pause hold and resume, load while paused, load/start ignored in RUN
        step("t2_pause",      0, 0, 0, 1, 0, 0, 0, 600, PAUSE, 0);
        step("t2_load_pause", 0, 0, 0, 1, 0, 1, 60, 60, PAUSE, 0);
        step("t2_resume",     0, 0, 0, 0, 0, 0, 0, 60, RUN, 0);
        for (int i = 1; i <= 10; i++)
            step($sformatf("t2_tick%0d", i), 0, 1, 0, 0, 0, 0, 0, 60 - i, RUN, 0);
        for (int i = 0; i < 20; i++)
            step($sformatf("t2_paused%0d", i), 0, 1, 0, 1, 0, 0, 0, 50, PAUSE, 0);
        step("t2_unpause",    0, 0, 0, 0, 0, 0, 0, 50, RUN, 0);
        step("t2_resume_tick", 0, 1, 0, 0, 0, 0, 0, 49, RUN, 0);
        step("t2_load_in_run", 0, 0, 0, 0, 0, 1, 3, 49, RUN, 0);
        step("t2_start_in_run", 0, 0, 1, 0, 0, 0, 0, 49, RUN, 0);

        // restart and load_en together at count 200
        reset_unit0("t5_rst");
        step("t5_start",      0, 0, 1, 0, 0, 0, 0, 600, RUN, 0);
        for (int i = 1; i <= 400; i++)
            step($sformatf("t5_cnt%0d", 600 - i), 0, 1, 0, 0, 0, 0, 0, 600 - i, RUN, 0);
        step("t5_restart_load", 0, 0, 0, 0, 1, 1, 9, 600, RUN, 0);
        step("t5_tick",       0, 1, 0, 0, 0, 0, 0, 599, RUN, 0);
        step("t5_reload_kept", 0, 0, 0, 0, 1, 0, 0, 600, RUN, 0);

        // zero load, expiry without tick, tick+pause same cycle
        reset_unit0("t6_rst");
        step("t6_load0",      0, 0, 0, 0, 0, 1, 0, 0, IDLE, 0);
        step("t6_start",      0, 0, 1, 0, 0, 0, 0, 0, RUN, 0);
        step("t6_expire",     0, 0, 0, 0, 0, 0, 0, 0, DONE, 1);
        step("t6_no_repeat",  0, 0, 0, 0, 0, 0, 0, 0, DONE, 0);
        step("t6_load_done",  0, 0, 0, 0, 0, 1, 30, 30, DONE, 0);
        step("t6_start30",    0, 0, 1, 0, 0, 0, 0, 30, RUN, 0);
        step("t6_tick_pause", 0, 1, 0, 1, 0, 0, 0, 30, PAUSE, 0);
        step("t6_restart_pause", 0, 0, 0, 0, 1, 0, 0, 30, RUN, 0);

        // auto-reload unit, reload value 3
        step("t4_load3",      1, 0, 0, 0, 0, 1, 3, 3, IDLE, 0);
        step("t4_start",      1, 0, 1, 0, 0, 0, 0, 3, RUN, 0);
        step("t4_a2",         1, 1, 0, 0, 0, 0, 0, 2, RUN, 0);
        step("t4_a1",         1, 1, 0, 0, 0, 0, 0, 1, RUN, 0);
        step("t4_a0",         1, 1, 0, 0, 0, 0, 0, 0, RUN, 0);
        step("t4_reload1",    1, 1, 0, 0, 0, 0, 0, 3, RUN, 1);
        step("t4_b2",         1, 1, 0, 0, 0, 0, 0, 2, RUN, 0);
        step("t4_b1",         1, 1, 0, 0, 0, 0, 0, 1, RUN, 0);
        step("t4_b0",         1, 1, 0, 0, 0, 0, 0, 0, RUN, 0);
        step("t4_reload2",    1, 1, 0, 0, 0, 0, 0, 3, RUN, 1);
        step("t4_c2",         1, 1, 0, 0, 0, 0, 0, 2, RUN, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
